// File: rtl/sipo_4bit_shift_reg_rx_if.sv
// Serial receive link bundle: serial bit/control toward the receiver, assembled word and status back.
interface sipo_4bit_shift_reg_rx_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic             s_in;
  logic             shift_en;
  logic             sync;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    bit_cnt;
  logic             busy;

  modport master (
    output s_in, shift_en, sync,
    input  q, dout, dout_valid, bit_cnt, busy
  );

  modport slave (
    input  s_in, shift_en, sync,
    output q, dout, dout_valid, bit_cnt, busy
  );
endinterface

// File: rtl/sipo_4bit_shift_reg_rx.sv
// Serial-in parallel-out receiver: shifts in one bit per enabled clock and
// publishes each completed WIDTH-bit word on dout with a one-cycle valid pulse.
module sipo_4bit_shift_reg_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sipo_4bit_shift_reg_rx_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [WIDTH-1:0] dout_r, dout_nxt;
  logic [WIDTH-1:0] shifted;
  logic             valid_r, valid_nxt;
  logic [CW-1:0]    cnt_r, cnt_nxt;
  logic             last_bit;

  // Shift direction decides where the first received bit finally lands.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shifted = {bus.s_in, q_r[WIDTH-1:1]};
    end else begin : g_msb_first
      assign shifted = {q_r[WIDTH-2:0], bus.s_in};
    end
  endgenerate

  assign last_bit = (cnt_r == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      q_r     <= '0;
      dout_r  <= '0;
      valid_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state   <= state_nxt;
      q_r     <= q_nxt;
      dout_r  <= dout_nxt;
      valid_r <= valid_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Next-state and datapath; sync outranks shift_en and drops that cycle's bit.
  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    dout_nxt  = dout_r;
    valid_nxt = 1'b0;
    cnt_nxt   = cnt_r;

    if (bus.sync) begin
      q_nxt   = '0;
      cnt_nxt = '0;
    end else if (bus.shift_en) begin
      q_nxt = shifted;
      if (last_bit) begin
        cnt_nxt   = '0;
        dout_nxt  = shifted;
        valid_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_r + CW'(1);
      end
    end

    case (state)
      IDLE: if (!bus.sync && bus.shift_en) state_nxt = RECV;
      RECV: if (bus.sync || (bus.shift_en && last_bit)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.q          = q_r;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = valid_r;
  assign bus.bit_cnt    = cnt_r;
  assign bus.busy       = (state == RECV);
endmodule
